// File: rtl/mio_bus_ctrl.sv
// Memory/IO bus controller: routes CPU accesses to a synchronous data RAM or to on-chip
// registers (LED, switches, countdown timer) and returns read data with a one-cycle ready pulse.
module mio_bus_ctrl #(
  parameter int unsigned RAM_AW = 10
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              cpu_mio,
  input  logic [31:0]       cpu_addr,
  input  logic [31:0]       cpu_wdata,
  input  logic              cpu_we,
  output logic [31:0]       cpu_rdata,
  output logic              mio_ready,
  output logic              int_out,
  output logic              ram_en,
  output logic              ram_we,
  output logic [RAM_AW-1:0] ram_addr,
  output logic [31:0]       ram_wdata,
  input  logic [31:0]       ram_rdata,
  input  logic [15:0]       sw_in,
  output logic [15:0]       led_out
);

  localparam logic [29:0] LedWord  = 30'h3C00_0000;
  localparam logic [29:0] SwWord   = 30'h3C00_0001;
  localparam logic [29:0] LoadWord = 30'h3C00_0002;
  localparam logic [29:0] CtrlWord = 30'h3C00_0003;

  typedef enum logic [1:0] {StIdle, StRamWait, StResp} state_e;

  state_e      state_q, state_d;
  logic [31:0] resp_q, resp_d;
  logic [15:0] led_q;
  logic [15:0] sw_meta_q, sw_sync_q;
  logic [31:0] load_q, count_q, count_d;
  logic        en_q, auto_q, pend_q, ie_q, pend_d;

  logic        is_ram;
  logic        reg_wr;
  logic        led_wr, load_wr, ctrl_wr;
  logic        expire;
  logic [31:0] reg_rdata;
  logic [29:0] word;
  logic        unused_addr;

  assign word        = cpu_addr[31:2];
  assign unused_addr = ^cpu_addr[1:0];
  assign is_ram      = (cpu_addr[31:RAM_AW+2] == '0);
  assign ram_addr    = cpu_addr[RAM_AW+1:2];
  assign ram_wdata   = cpu_wdata;

  always_comb begin
    reg_rdata = '0;
    if (word == LedWord)       reg_rdata = {16'h0, led_q};
    else if (word == SwWord)   reg_rdata = {16'h0, sw_sync_q};
    else if (word == LoadWord) reg_rdata = count_q;
    else if (word == CtrlWord) reg_rdata = {28'h0, ie_q, pend_q, auto_q, en_q};
  end

  always_comb begin
    state_d = state_q;
    resp_d  = resp_q;
    ram_en  = 1'b0;
    ram_we  = 1'b0;
    reg_wr  = 1'b0;
    unique case (state_q)
      StIdle: begin
        if (cpu_mio) begin
          if (is_ram) begin
            ram_en  = 1'b1;
            ram_we  = cpu_we;
            resp_d  = '0;
            state_d = cpu_we ? StResp : StRamWait;
          end else begin
            reg_wr  = cpu_we;
            resp_d  = cpu_we ? 32'h0 : reg_rdata;
            state_d = StResp;
          end
        end
      end
      StRamWait: begin
        resp_d  = ram_rdata;
        state_d = StResp;
      end
      StResp:  state_d = StIdle;
      default: state_d = StIdle;
    endcase
  end

  assign led_wr  = reg_wr && (word == LedWord);
  assign load_wr = reg_wr && (word == LoadWord);
  assign ctrl_wr = reg_wr && (word == CtrlWord);

  // A LOAD write overrides the decrement, so no expiry is seen on that edge.
  assign expire = en_q && (count_q == 32'd1) && !load_wr;

  always_comb begin
    count_d = count_q;
    if (load_wr) begin
      count_d = cpu_wdata;
    end else if (en_q && (count_q != 32'd0)) begin
      if (expire) count_d = auto_q ? load_q : 32'd0;
      else        count_d = count_q - 32'd1;
    end
  end

  // Expiry takes priority over a simultaneous write-1-to-clear.
  always_comb begin
    pend_d = pend_q;
    if (expire)                      pend_d = 1'b1;
    else if (ctrl_wr && cpu_wdata[2]) pend_d = 1'b0;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q   <= StIdle;
      resp_q    <= '0;
      led_q     <= '0;
      sw_meta_q <= '0;
      sw_sync_q <= '0;
      load_q    <= '0;
      count_q   <= '0;
      en_q      <= 1'b0;
      auto_q    <= 1'b0;
      pend_q    <= 1'b0;
      ie_q      <= 1'b0;
    end else begin
      state_q   <= state_d;
      resp_q    <= resp_d;
      sw_meta_q <= sw_in;
      sw_sync_q <= sw_meta_q;
      count_q   <= count_d;
      pend_q    <= pend_d;
      if (led_wr)  led_q  <= cpu_wdata[15:0];
      if (load_wr) load_q <= cpu_wdata;
      if (ctrl_wr) begin
        en_q   <= cpu_wdata[0];
        auto_q <= cpu_wdata[1];
        ie_q   <= cpu_wdata[3];
      end
    end
  end

  assign mio_ready = (state_q == StResp);
  assign cpu_rdata = mio_ready ? resp_q : 32'h0;
  assign int_out   = pend_q & ie_q;
  assign led_out   = led_q;

endmodule

// File: tb/tb_mio_bus_ctrl.sv
// Directed bench for mio_bus_ctrl: bus accesses with hand-computed latency/data, timer
// one-shot and auto-reload sequences, and reset during an outstanding RAM read.
module tb_mio_bus_ctrl;

  logic        clk;
  logic        rst;
  logic        cpu_mio;
  logic [31:0] cpu_addr;
  logic [31:0] cpu_wdata;
  logic        cpu_we;
  logic [31:0] cpu_rdata;
  logic        mio_ready;
  logic        int_out;
  logic        ram_en;
  logic        ram_we;
  logic [9:0]  ram_addr;
  logic [31:0] ram_wdata;
  logic [31:0] ram_rdata;
  logic [15:0] sw_in;
  logic [15:0] led_out;

  int tests_run;
  int tests_failed;

  logic        c0_en, c0_we, late_en, int_at_ready;
  logic [9:0]  c0_addr;
  logic [31:0] ram_mem [1024];

  mio_bus_ctrl #(.RAM_AW(10)) dut (
    .clk       (clk),
    .rst       (rst),
    .cpu_mio   (cpu_mio),
    .cpu_addr  (cpu_addr),
    .cpu_wdata (cpu_wdata),
    .cpu_we    (cpu_we),
    .cpu_rdata (cpu_rdata),
    .mio_ready (mio_ready),
    .int_out   (int_out),
    .ram_en    (ram_en),
    .ram_we    (ram_we),
    .ram_addr  (ram_addr),
    .ram_wdata (ram_wdata),
    .ram_rdata (ram_rdata),
    .sw_in     (sw_in),
    .led_out   (led_out)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Synchronous RAM model: read data valid the cycle after ram_en.
  always @(posedge clk) begin
    if (ram_en) begin
      if (ram_we) ram_mem[ram_addr] <= ram_wdata;
      ram_rdata <= ram_mem[ram_addr];
    end
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests_run++;
    assert (obs === exp) else begin
      tests_failed++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Entered just after a negedge in IDLE; returns at the negedge of the following IDLE cycle.
  task automatic access(input string tag, input logic [31:0] addr, input logic [31:0] wdata,
                        input logic we, input int exp_lat, input logic [31:0] exp_rdata);
    int lat;
    cpu_addr  = addr;
    cpu_wdata = wdata;
    cpu_we    = we;
    cpu_mio   = 1'b1;
    #1;
    c0_en   = ram_en;
    c0_we   = ram_we;
    c0_addr = ram_addr;
    late_en = 1'b0;
    lat     = 0;
    do begin
      @(negedge clk);
      lat++;
      if (ram_en) late_en = 1'b1;
    end while (!mio_ready && lat < 8);
    int_at_ready = int_out;
    check({tag, " latency"}, 32'(lat), 32'(exp_lat));
    check({tag, " rdata"}, cpu_rdata, exp_rdata);
    cpu_mio = 1'b0;
    cpu_we  = 1'b0;
    @(negedge clk);
  endtask

  initial begin
    tests_run    = 0;
    tests_failed = 0;
    rst       = 1'b0;
    cpu_mio   = 1'b0;
    cpu_addr  = '0;
    cpu_wdata = '0;
    cpu_we    = 1'b0;
    sw_in     = '0;
    ram_rdata = '0;
    #1;
    check("reset mio_ready", {31'h0, mio_ready}, 32'h0);
    check("reset cpu_rdata", cpu_rdata, 32'h0);
    check("reset led_out", {16'h0, led_out}, 32'h0);
    check("reset int_out", {31'h0, int_out}, 32'h0);
    check("reset ram_en", {31'h0, ram_en}, 32'h0);
    @(negedge clk);
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);

    // RAM write then read back
    access("ram wr", 32'h0000_0010, 32'hDEAD_BEEF, 1'b1, 1, 32'h0);
    check("ram wr en", {31'h0, c0_en}, 32'h1);
    check("ram wr we", {31'h0, c0_we}, 32'h1);
    check("ram wr addr", {22'h0, c0_addr}, 32'h4);
    access("ram rd", 32'h0000_0010, 32'h0, 1'b0, 2, 32'hDEAD_BEEF);
    check("ram rd en", {31'h0, c0_en}, 32'h1);
    check("ram rd we", {31'h0, c0_we}, 32'h0);
    check("ram rd late en", {31'h0, late_en}, 32'h0);

    // LED and switches
    access("led wr", 32'hF000_0000, 32'h1234_A5A5, 1'b1, 1, 32'h0);
    check("led_out", {16'h0, led_out}, 32'h0000_A5A5);
    check("led wr ram_en", {31'h0, c0_en}, 32'h0);
    access("led rd", 32'hF000_0000, 32'h0, 1'b0, 1, 32'h0000_A5A5);
    sw_in = 16'h00FF;
    repeat (3) @(negedge clk);
    access("sw rd", 32'hF000_0004, 32'h0, 1'b0, 1, 32'h0000_00FF);

    // Unmapped
    access("unmapped rd", 32'h8000_0000, 32'h0, 1'b0, 1, 32'h0);
    check("unmapped ram_en", {31'h0, c0_en | late_en}, 32'h0);

    // Timer one-shot: EN at write edge P0, expiry at P3
    access("load 3", 32'hF000_0008, 32'd3, 1'b1, 1, 32'h0);
    access("ctrl 9", 32'hF000_000C, 32'h9, 1'b1, 1, 32'h0);
    check("oneshot int P1", {31'h0, int_out}, 32'h0);
    @(negedge clk);
    check("oneshot int P2", {31'h0, int_out}, 32'h0);
    @(negedge clk);
    check("oneshot int P3", {31'h0, int_out}, 32'h1);
    access("oneshot count", 32'hF000_0008, 32'h0, 1'b0, 1, 32'h0);
    access("oneshot ctrl", 32'hF000_000C, 32'h0, 1'b0, 1, 32'h0000_000D);
    access("clear D", 32'hF000_000C, 32'hD, 1'b1, 1, 32'h0);
    check("cleared int", {31'h0, int_out}, 32'h0);

    // Timer auto-reload, period 2, expiries at P2, P4, P6, P8
    access("ctrl 0", 32'hF000_000C, 32'h0, 1'b1, 1, 32'h0);
    access("load 2", 32'hF000_0008, 32'd2, 1'b1, 1, 32'h0);
    access("ctrl B", 32'hF000_000C, 32'hB, 1'b1, 1, 32'h0);
    check("auto int P1", {31'h0, int_out}, 32'h0);
    @(negedge clk);
    check("auto int P2", {31'h0, int_out}, 32'h1);
    @(negedge clk);
    access("clear on expiry", 32'hF000_000C, 32'hF, 1'b1, 1, 32'h0);
    check("collision pend kept", {31'h0, int_out}, 32'h1);
    @(negedge clk);
    access("clear off expiry", 32'hF000_000C, 32'hF, 1'b1, 1, 32'h0);
    check("clear took effect", {31'h0, int_at_ready}, 32'h0);
    check("auto int P8", {31'h0, int_out}, 32'h1);

    // Reset during RAM_WAIT
    cpu_addr = 32'h0000_0010;
    cpu_we   = 1'b0;
    cpu_mio  = 1'b1;
    @(negedge clk);
    check("pre-reset int", {31'h0, int_out}, 32'h1);
    check("pre-reset ready", {31'h0, mio_ready}, 32'h0);
    rst = 1'b0;
    #1;
    check("mid reset ready", {31'h0, mio_ready}, 32'h0);
    check("mid reset led", {16'h0, led_out}, 32'h0);
    check("mid reset int", {31'h0, int_out}, 32'h0);
    cpu_mio = 1'b0;
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    check("post reset ready", {31'h0, mio_ready}, 32'h0);
    access("post reset led", 32'hF000_0000, 32'h0, 1'b0, 1, 32'h0);
    access("post reset ctrl", 32'hF000_000C, 32'h0, 1'b0, 1, 32'h0);

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
